// File: rtl/exp_result_fifo.sv
// exp_result_fifo: first-word fall-through result buffer behind the exponential
// pipeline. o_ready is the pipeline's global stall enable. All status outputs
// decode registered state only, so no input reaches an output combinationally.
// o_total counts accepted writes and wraps modulo 2^16.
module exp_result_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_valid,
    input  logic [WIDTH-1:0]         i_y,
    output logic                     o_ready,
    output logic                     o_valid,
    output logic [WIDTH-1:0]         o_y,
    input  logic                     i_ready,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic [15:0]              o_total
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic [15:0]      total_q,  total_d;
    logic             wr_en;
    logic             rd_en;

    // Status and head data decoded purely from registered state.
    assign o_ready = (count_q != FULL_CNT);
    assign o_valid = (count_q != '0);
    assign o_y     = o_valid ? mem_q[rd_ptr_q] : '0;
    assign o_count = count_q;
    assign o_total = total_q;

    // Next-state logic: accept/release events, pointer and counter updates.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        wr_en    = i_valid & o_ready;
        rd_en    = o_valid & i_ready;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        total_d  = total_q;
        mem_d    = mem_q;

        if (wr_en) begin
            mem_d[wr_ptr_q] = i_y;
            // Power-of-two depth: the natural pointer overflow is the modulo wrap.
            wr_ptr_d = wr_ptr_q + 1'b1;
            total_d  = total_q + 16'd1;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state: synchronous reset wins over any same-cycle event.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            total_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            total_q  <= total_d;
        end
    end

    // Storage array update.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; count_q=0 already masks stale words from o_y.
        mem_q <= mem_d;
    end

endmodule
